// File: rtl/seg7_scan_ctrl_if.sv
// IO write stream from the CPU memory/IO steering stage into the seven-segment display slot.
interface seg7_scan_ctrl_if;
   logic        seg_write;
   logic        seg_cs;
   logic [1:0]  seg_addr;
   logic [15:0] seg_wdata;

   modport master (output seg_write, output seg_cs, output seg_addr, output seg_wdata);
   modport slave  (input  seg_write, input  seg_cs, input  seg_addr, input  seg_wdata);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed seven-segment controller: write-only registers, a digit scan counter,
// and registered active-low anode/segment drive with leading-zero blanking.
module seg7_scan_ctrl #(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic              clock,
   input  logic              reset,
   seg7_scan_ctrl_if.slave   bus,
   output logic [7:0]        seg_an,
   output logic [7:0]        seg_out,
   output logic              frame_tick
);

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [31:0]      disp_val_q,   disp_val_d;
   logic [7:0]       digit_en_q,   digit_en_d;
   logic [7:0]       dp_mask_q,    dp_mask_d;
   logic             lz_blank_q,   lz_blank_d;
   logic             disp_on_q,    disp_on_d;
   logic [DIV_W-1:0] div_cnt_q,    div_cnt_d;
   logic [2:0]       digit_idx_q,  digit_idx_d;
   logic [7:0]       seg_an_q,     seg_an_d;
   logic [7:0]       seg_out_q,    seg_out_d;
   logic             frame_tick_q, frame_tick_d;

   logic [7:0] lead_zero;
   logic       nz_seen;
   logic       slot_end;
   logic       lit;
   logic [3:0] nibble;

   function automatic logic [6:0] hex_decode(input logic [3:0] n);
      logic [7:0] s;
      case (n)
         4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
         4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
         4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
         4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
      endcase
      return s[6:0];
   endfunction

   // lead_zero[i]: nibbles 7..i all zero; digit 0 is never a leading zero.
   always_comb begin
      nz_seen   = 1'b0;
      lead_zero = '0;
      for (int i = 7; i >= 1; i--) begin
         nz_seen      = nz_seen | (|disp_val_q[4*i +: 4]);
         lead_zero[i] = ~nz_seen;
      end
   end

   always_comb begin
      disp_val_d   = disp_val_q;
      digit_en_d   = digit_en_q;
      dp_mask_d    = dp_mask_q;
      lz_blank_d   = lz_blank_q;
      disp_on_d    = disp_on_q;

      if (bus.seg_write && bus.seg_cs) begin
         case (bus.seg_addr)
            2'b00: disp_val_d[15:0]  = bus.seg_wdata;
            2'b10: disp_val_d[31:16] = bus.seg_wdata;
            2'b01: begin
               digit_en_d = bus.seg_wdata[7:0];
               dp_mask_d  = bus.seg_wdata[15:8];
            end
            default: begin
               lz_blank_d = bus.seg_wdata[0];
               disp_on_d  = bus.seg_wdata[1];
            end
         endcase
      end

      // Scan timing is independent of register writes.
      slot_end     = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
      div_cnt_d    = slot_end ? '0 : div_cnt_q + DIV_W'(1);
      digit_idx_d  = slot_end ? digit_idx_q + 3'd1 : digit_idx_q;
      frame_tick_d = slot_end && (digit_idx_q == 3'd7);

      nibble    = disp_val_q[{digit_idx_q, 2'b00} +: 4];
      lit       = disp_on_q && digit_en_q[digit_idx_q]
                  && !(lz_blank_q && lead_zero[digit_idx_q]);
      seg_an_d  = lit ? ~(8'b1 << digit_idx_q) : 8'hFF;
      seg_out_d = lit ? {~dp_mask_q[digit_idx_q], hex_decode(nibble)} : 8'hFF;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         disp_val_q   <= '0;
         digit_en_q   <= 8'hFF;
         dp_mask_q    <= '0;
         lz_blank_q   <= 1'b0;
         disp_on_q    <= 1'b1;
         div_cnt_q    <= '0;
         digit_idx_q  <= '0;
         seg_an_q     <= 8'hFF;
         seg_out_q    <= 8'hFF;
         frame_tick_q <= 1'b0;
      end else begin
         disp_val_q   <= disp_val_d;
         digit_en_q   <= digit_en_d;
         dp_mask_q    <= dp_mask_d;
         lz_blank_q   <= lz_blank_d;
         disp_on_q    <= disp_on_d;
         div_cnt_q    <= div_cnt_d;
         digit_idx_q  <= digit_idx_d;
         seg_an_q     <= seg_an_d;
         seg_out_q    <= seg_out_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign seg_an     = seg_an_q;
   assign seg_out    = seg_out_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl with SCAN_DIV=4.
module tb_seg7_scan_ctrl;

   logic       clock;
   logic       reset;
   logic [7:0] seg_an;
   logic [7:0] seg_out;
   logic       frame_tick;
   int         errors;
   int         checks;

   seg7_scan_ctrl_if bus();

   seg7_scan_ctrl #(.SCAN_DIV(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus.slave),
      .seg_an     (seg_an),
      .seg_out    (seg_out),
      .frame_tick (frame_tick)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [15:0] d,
                            input logic cs, input logic we);
      bus.seg_addr  = a;
      bus.seg_wdata = d;
      bus.seg_cs    = cs;
      bus.seg_write = we;
      step();
      bus.seg_cs    = 1'b0;
      bus.seg_write = 1'b0;
   endtask

   // Sync to a frame_tick, then record what each digit slot 0..7 drives.
   task automatic capture_frame(output logic [63:0] an, output logic [63:0] sg, output bit ok);
      ok = 1'b0;
      an = '0;
      sg = '0;
      for (int i = 0; i < 80; i++) begin
         step();
         if (frame_tick === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         for (int d = 0; d < 8; d++) begin
            step();
            an[8*d +: 8] = seg_an;
            sg[8*d +: 8] = seg_out;
            repeat (3) step();
         end
      end
   endtask

   task automatic test_reset();
      logic [7:0] exp_an;
      logic       exp_ft;
      reset = 1'b1;
      step();
      step();
      checks++;
      if (seg_an !== 8'hFF || seg_out !== 8'hFF || frame_tick !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got an=%h seg=%h ft=%b want an=ff seg=ff ft=0",
                  seg_an, seg_out, frame_tick);
      end
      reset = 1'b0;
      for (int e = 1; e <= 64; e++) begin
         step();
         exp_an = ~(8'b1 << (((e - 1) / 4) % 8));
         exp_ft = ((e % 32) == 0);
         checks++;
         if (seg_an !== exp_an || seg_out !== 8'hC0 || frame_tick !== exp_ft) begin
            errors++;
            $display("FAIL scan_edge %0d: got an=%h seg=%h ft=%b want an=%h seg=c0 ft=%b",
                     e, seg_an, seg_out, frame_tick, exp_an, exp_ft);
         end
      end
   endtask

   task automatic test_latency();
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      checks++;
      if (seg_an !== 8'hFE || seg_out !== 8'hC0) begin
         errors++;
         $display("FAIL lat_start: got an=%h seg=%h want fe c0", seg_an, seg_out);
      end
      bus_write(2'b00, 16'h0009, 1'b1, 1'b1);
      checks++;
      if (seg_out !== 8'hC0) begin
         errors++;
         $display("FAIL lat_write_edge: got seg=%h want c0", seg_out);
      end
      step();
      checks++;
      if (seg_an !== 8'hFE || seg_out !== 8'h90) begin
         errors++;
         $display("FAIL lat_next_edge: got an=%h seg=%h want fe 90", seg_an, seg_out);
      end
      // write lands on the digit-advance edge
      bus_write(2'b00, 16'h0010, 1'b1, 1'b1);
      checks++;
      if (seg_an !== 8'hFE || seg_out !== 8'h90) begin
         errors++;
         $display("FAIL lat_adv_edge: got an=%h seg=%h want fe 90", seg_an, seg_out);
      end
      step();
      checks++;
      if (seg_an !== 8'hFD || seg_out !== 8'hF9) begin
         errors++;
         $display("FAIL lat_adv_next: got an=%h seg=%h want fd f9", seg_an, seg_out);
      end
   endtask

   task automatic test_hex_digits();
      logic [63:0] an, sg;
      bit          ok;
      logic [7:0]  es [8] = '{8'h8E, 8'hB0, 8'h88, 8'h92, 8'hC0, 8'h80, 8'hA4, 8'hF9};
      bus_write(2'b00, 16'h5A3F, 1'b1, 1'b1);
      bus_write(2'b10, 16'h1280, 1'b1, 1'b1);
      capture_frame(an, sg, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL hex_sync: got no frame_tick want one"); end
      for (int d = 0; d < 8; d++) begin
         checks++;
         if (an[8*d +: 8] !== ~(8'b1 << d) || sg[8*d +: 8] !== es[d]) begin
            errors++;
            $display("FAIL hex_digit %0d: got an=%h seg=%h want an=%h seg=%h",
                     d, an[8*d +: 8], sg[8*d +: 8], ~(8'b1 << d), es[d]);
         end
      end
   endtask

   task automatic test_lz_blank();
      logic [63:0] an, sg;
      bit          ok;
      logic [7:0]  ea [8] = '{8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      logic [7:0]  es [8] = '{8'h92, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      bus_write(2'b00, 16'h00A5, 1'b1, 1'b1);
      bus_write(2'b10, 16'h0000, 1'b1, 1'b1);
      bus_write(2'b11, 16'h0003, 1'b1, 1'b1);
      capture_frame(an, sg, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL lz_sync: got no frame_tick want one"); end
      for (int d = 0; d < 8; d++) begin
         checks++;
         if (an[8*d +: 8] !== ea[d] || sg[8*d +: 8] !== es[d]) begin
            errors++;
            $display("FAIL lz_digit %0d: got an=%h seg=%h want an=%h seg=%h",
                     d, an[8*d +: 8], sg[8*d +: 8], ea[d], es[d]);
         end
      end
      bus_write(2'b00, 16'h0000, 1'b1, 1'b1);
      capture_frame(an, sg, ok);
      for (int d = 0; d < 8; d++) begin
         checks++;
         if (an[8*d +: 8] !== ((d == 0) ? 8'hFE : 8'hFF) ||
             sg[8*d +: 8] !== ((d == 0) ? 8'hC0 : 8'hFF)) begin
            errors++;
            $display("FAIL lz_zero_digit %0d: got an=%h seg=%h want only digit 0 lit with c0",
                     d, an[8*d +: 8], sg[8*d +: 8]);
         end
      end
   endtask

   task automatic test_digit_en_dp();
      logic [63:0] an, sg;
      bit          ok;
      logic [7:0]  dec [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
      logic [7:0]  ea, es;
      bus_write(2'b11, 16'h0002, 1'b1, 1'b1);
      bus_write(2'b00, 16'h3210, 1'b1, 1'b1);
      bus_write(2'b10, 16'h7654, 1'b1, 1'b1);
      bus_write(2'b01, 16'h05F0, 1'b1, 1'b1);
      capture_frame(an, sg, ok);
      for (int d = 0; d < 8; d++) begin
         ea = (d < 4) ? 8'hFF : ~(8'b1 << d);
         es = (d < 4) ? 8'hFF : dec[d];
         checks++;
         if (an[8*d +: 8] !== ea || sg[8*d +: 8] !== es) begin
            errors++;
            $display("FAIL en_digit %0d: got an=%h seg=%h want an=%h seg=%h",
                     d, an[8*d +: 8], sg[8*d +: 8], ea, es);
         end
      end
      bus_write(2'b01, 16'h01FF, 1'b1, 1'b1);
      capture_frame(an, sg, ok);
      for (int d = 0; d < 8; d++) begin
         es = (d == 0) ? 8'h40 : dec[d];
         checks++;
         if (an[8*d +: 8] !== ~(8'b1 << d) || sg[8*d +: 8] !== es) begin
            errors++;
            $display("FAIL dp_digit %0d: got an=%h seg=%h want an=%h seg=%h",
                     d, an[8*d +: 8], sg[8*d +: 8], ~(8'b1 << d), es);
         end
      end
   endtask

   task automatic test_write_gating();
      logic [63:0] an, sg;
      bit          ok;
      int          gap;
      bus_write(2'b00, 16'hFFFF, 1'b1, 1'b0);
      bus_write(2'b00, 16'hFFFF, 1'b0, 1'b1);
      capture_frame(an, sg, ok);
      checks++;
      if (sg !== 64'hF8_82_92_99_B0_A4_F9_40 || an !== 64'h7F_BF_DF_EF_F7_FB_FD_FE) begin
         errors++;
         $display("FAIL gate_frame: got an=%h seg=%h want an=7fbfdfeff7fbfdfe seg=f8829299b0a4f940",
                  an, sg);
      end
      bus_write(2'b11, 16'h0000, 1'b1, 1'b1);
      capture_frame(an, sg, ok);
      checks++;
      if (!ok || an !== {8{8'hFF}} || sg !== {8{8'hFF}}) begin
         errors++;
         $display("FAIL off_frame: got ok=%b an=%h seg=%h want ok=1 all ff", ok, an, sg);
      end
      gap = 0;
      for (int i = 0; i < 80; i++) begin
         step();
         if (frame_tick === 1'b1) break;
      end
      for (int i = 0; i < 80; i++) begin
         step();
         gap++;
         if (frame_tick === 1'b1) break;
      end
      checks++;
      if (gap != 32) begin
         errors++;
         $display("FAIL tick_period: got %0d cycles want 32", gap);
      end
   endtask

   task automatic test_reset_mid_scan();
      bit found;
      bus_write(2'b11, 16'h0002, 1'b1, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 80; i++) begin
         step();
         if (frame_tick === 1'b1) begin found = 1'b1; break; end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL mid_sync: got no frame_tick want one"); end
      repeat (22) step();
      checks++;
      if (seg_an !== 8'hDF || seg_out !== 8'h92) begin
         errors++;
         $display("FAIL mid_position: got an=%h seg=%h want df 92", seg_an, seg_out);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (seg_an !== 8'hFF || seg_out !== 8'hFF || frame_tick !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got an=%h seg=%h ft=%b want ff ff 0", seg_an, seg_out, frame_tick);
      end
      for (int e = 1; e <= 5; e++) begin
         step();
         checks++;
         if (seg_an !== ((e <= 4) ? 8'hFE : 8'hFD) || seg_out !== 8'hC0) begin
            errors++;
            $display("FAIL mid_restart edge %0d: got an=%h seg=%h want an=%h seg=c0",
                     e, seg_an, seg_out, (e <= 4) ? 8'hFE : 8'hFD);
         end
      end
   endtask

   initial begin
      errors        = 0;
      checks        = 0;
      reset         = 1'b1;
      bus.seg_write = 1'b0;
      bus.seg_cs    = 1'b0;
      bus.seg_addr  = 2'b00;
      bus.seg_wdata = 16'h0000;
      test_reset();
      test_latency();
      test_hex_digits();
      test_lz_blank();
      test_digit_en_dp();
      test_write_gating();
      test_reset_mid_scan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
